// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer: command opcodes, FSM state
// encodings and small helpers used by the top and its interrupt encoder.
package bus_sequencer_pkg;

    localparam int CMD_OP_W = 3;

    // Commands issued by the execute stage
    typedef enum logic [CMD_OP_W-1:0] {
        CMD_FETCH = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STORE = 3'd2,
        CMD_PUSH  = 3'd3,
        CMD_POP   = 3'd4,
        CMD_JUMP  = 3'd5,
        CMD_HALT  = 3'd6
    } cmd_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE     = 2'd0,
        SEQ_ACCESS   = 2'd1,
        SEQ_IRQ_PUSH = 2'd2,
        SEQ_HALTED   = 2'd3
    } seq_state_e;

    // Width of an index into n items; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_sequencer_irq_priority_enc.sv
// Combinational fixed-priority interrupt encoder: the lowest set request
// wins. Produces the winning index, an any-request flag and a one-hot grant.
module bus_sequencer_irq_priority_enc #(
    parameter int IRQ_N = 8,
    parameter int IDX_W = 3
) (
    input  logic [IRQ_N-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [IRQ_N-1:0] grant
);

    genvar gi;

    // A line is granted when it requests and no lower-numbered line does
    generate
        for (gi = 0; gi < IRQ_N; gi++) begin : g_grant
            if (gi == 0) begin : g_first
                assign grant[gi] = req[gi];
            end else begin : g_rest
                assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    assign valid = |req;

    // Convert the one-hot grant into a binary index
    always_comb begin
        idx = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (grant[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Memory-bus sequencer for the CPU core. Runs fetch/load/store/push/pop/jump/
// halt commands over a cmd/rsp handshake, owns PC and SP, drives the
// address/data bus with r/w strobes, honours wait states via mem_ready and
// performs prioritised interrupt entry (push PC, vector to VECTOR_BASE+idx).
//
// Build option: define CPU_BUS_TIMEOUT_EN to abort any bus access that stalls
// for WAIT_MAX consecutive cycles; the sequencer then pulses bus_error and
// halts. Without it accesses wait indefinitely and bus_error stays 0.
module bus_sequencer #(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 16,
    parameter int unsigned RESET_PC    = 'h0000,
    parameter int unsigned SP_INIT     = 'h07FF,
    parameter int          IRQ_N       = 8,
    parameter int unsigned VECTOR_BASE = 'hFF00,
    parameter int          WAIT_MAX    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              ie,
    input  logic [IRQ_N-1:0]  interrupts,
    output logic [IRQ_N-1:0]  irq_ack,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              r,
    output logic              w,
    input  logic              mem_ready,
    output logic              halt,
    output logic              bus_error
);

    import bus_sequencer_pkg::*;

    localparam int IDX_W = idx_width(IRQ_N);

    if (WAIT_MAX < 1 || IRQ_N < 1) begin : g_param_check
        $error("bus_sequencer: WAIT_MAX and IRQ_N must both be at least 1");
    end

    seq_state_e        state_reg;
    cmd_op_e           op_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] sp_reg;
    logic [ADDR_W-1:0] address_bus_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              r_reg;
    logic              w_reg;
    logic              halt_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [IRQ_N-1:0]  irq_ack_reg;
    logic [IRQ_N-1:0]  irq_grant_reg;
    logic [IDX_W-1:0]  irq_idx_reg;
    logic              bus_error_reg;

    logic              irq_valid;
    logic [IDX_W-1:0]  irq_idx;
    logic [IRQ_N-1:0]  irq_grant;
    logic              irq_take;
    logic              bus_busy;
    logic              timeout_hit;

    bus_sequencer_irq_priority_enc #(
        .IRQ_N (IRQ_N),
        .IDX_W (IDX_W)
    ) u_irq_enc (
        .req   (interrupts),
        .valid (irq_valid),
        .idx   (irq_idx),
        .grant (irq_grant)
    );

    // Interrupts are only taken between bus transactions, and they pre-empt
    // any command offered in the same cycle.
    assign irq_take  = ie && irq_valid &&
                       ((state_reg == SEQ_IDLE) || (state_reg == SEQ_HALTED));
    assign cmd_ready = (state_reg == SEQ_IDLE) && !irq_take;
    assign bus_busy  = (state_reg == SEQ_ACCESS) || (state_reg == SEQ_IRQ_PUSH);

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    logic [WAIT_W-1:0] wait_cnt_reg;

    // Count consecutive stalled cycles of the access currently on the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (bus_busy && !mem_ready) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // This edge would be the WAIT_MAX-th stalled cycle in a row
    assign timeout_hit = bus_busy && !mem_ready &&
                         (wait_cnt_reg == WAIT_W'(WAIT_MAX - 1));
`else
    // No watchdog: accesses simply wait for mem_ready; bus_error_reg never sets
    assign timeout_hit = 1'b0;
`endif

    // Main sequencer FSM with all bus, response and status outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= SEQ_IDLE;
            op_reg          <= CMD_FETCH;
            pc_reg          <= ADDR_W'(RESET_PC);
            sp_reg          <= ADDR_W'(SP_INIT);
            address_bus_reg <= '0;
            wdata_reg       <= '0;
            r_reg           <= 1'b0;
            w_reg           <= 1'b0;
            halt_reg        <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            irq_ack_reg     <= '0;
            irq_grant_reg   <= '0;
            irq_idx_reg     <= '0;
            bus_error_reg   <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless set below
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            irq_ack_reg   <= '0;
            bus_error_reg <= 1'b0;

            unique case (state_reg)
                SEQ_IDLE, SEQ_HALTED: begin
                    if (irq_take) begin
                        // Save the return PC on the stack before vectoring
                        state_reg       <= SEQ_IRQ_PUSH;
                        address_bus_reg <= sp_reg;
                        wdata_reg       <= DATA_W'(pc_reg);
                        w_reg           <= 1'b1;
                        irq_grant_reg   <= irq_grant;
                        irq_idx_reg     <= irq_idx;
                    end else if (cmd_valid && cmd_ready) begin
                        op_reg <= cmd_op_e'(cmd_op);
                        case (cmd_op)
                            CMD_FETCH: begin
                                address_bus_reg <= pc_reg;
                                r_reg           <= 1'b1;
                                state_reg       <= SEQ_ACCESS;
                            end
                            CMD_LOAD: begin
                                address_bus_reg <= cmd_addr;
                                r_reg           <= 1'b1;
                                state_reg       <= SEQ_ACCESS;
                            end
                            CMD_STORE: begin
                                address_bus_reg <= cmd_addr;
                                wdata_reg       <= cmd_wdata;
                                w_reg           <= 1'b1;
                                state_reg       <= SEQ_ACCESS;
                            end
                            CMD_PUSH: begin
                                // SP points at the next free slot
                                address_bus_reg <= sp_reg;
                                wdata_reg       <= cmd_wdata;
                                w_reg           <= 1'b1;
                                state_reg       <= SEQ_ACCESS;
                            end
                            CMD_POP: begin
                                address_bus_reg <= sp_reg + ADDR_W'(1);
                                r_reg           <= 1'b1;
                                state_reg       <= SEQ_ACCESS;
                            end
                            CMD_JUMP: begin
                                pc_reg        <= cmd_addr;
                                rsp_valid_reg <= 1'b1;
                            end
                            CMD_HALT: begin
                                state_reg     <= SEQ_HALTED;
                                halt_reg      <= 1'b1;
                                rsp_valid_reg <= 1'b1;
                            end
                            default: begin
                                // Unused opcode: acknowledge so the core never stalls
                                rsp_valid_reg <= 1'b1;
                            end
                        endcase
                    end
                end

                SEQ_ACCESS: begin
                    if (mem_ready) begin
                        r_reg         <= 1'b0;
                        w_reg         <= 1'b0;
                        state_reg     <= SEQ_IDLE;
                        rsp_valid_reg <= 1'b1;
                        case (op_reg)
                            CMD_FETCH: begin
                                rsp_data_reg <= data_bus;
                                pc_reg       <= pc_reg + ADDR_W'(1);
                            end
                            CMD_LOAD: begin
                                rsp_data_reg <= data_bus;
                            end
                            CMD_PUSH: begin
                                sp_reg <= sp_reg - ADDR_W'(1);
                            end
                            CMD_POP: begin
                                rsp_data_reg <= data_bus;
                                sp_reg       <= sp_reg + ADDR_W'(1);
                            end
                            default: begin
                            end
                        endcase
                    end else if (timeout_hit) begin
                        r_reg         <= 1'b0;
                        w_reg         <= 1'b0;
                        halt_reg      <= 1'b1;
                        bus_error_reg <= 1'b1;
                        state_reg     <= SEQ_HALTED;
                    end
                end

                SEQ_IRQ_PUSH: begin
                    if (mem_ready) begin
                        w_reg       <= 1'b0;
                        sp_reg      <= sp_reg - ADDR_W'(1);
                        pc_reg      <= ADDR_W'(VECTOR_BASE) + ADDR_W'(irq_idx_reg);
                        irq_ack_reg <= irq_grant_reg;
                        halt_reg    <= 1'b0;
                        state_reg   <= SEQ_IDLE;
                    end else if (timeout_hit) begin
                        w_reg         <= 1'b0;
                        halt_reg      <= 1'b1;
                        bus_error_reg <= 1'b1;
                        state_reg     <= SEQ_HALTED;
                    end
                end

                default: begin
                    state_reg <= SEQ_IDLE;
                end
            endcase
        end
    end

    // The data bus is only driven while a write strobe is up
    assign data_bus    = w_reg ? wdata_reg : {DATA_W{1'bz}};

    assign address_bus = address_bus_reg;
    assign r           = r_reg;
    assign w           = w_reg;
    assign halt        = halt_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign irq_ack     = irq_ack_reg;
    assign bus_error   = bus_error_reg;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed testbench for bus_sequencer: reset state, fetch/load/store/push/
// pop/jump/halt sequencing, wait states, SP wrap-around, interrupt priority
// and entry, halt behaviour, reset mid-access and (when CPU_BUS_TIMEOUT_EN
// is defined) the bus timeout.
module tb_bus_sequencer;

    import bus_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        ie;
    logic [7:0]  interrupts;
    logic [7:0]  irq_ack;
    logic [15:0] address_bus;
    wire  [15:0] data_bus;
    logic        r;
    logic        w;
    logic        mem_ready;
    logic        halt;
    logic        bus_error;

    logic        mem_drive;
    logic [15:0] mem_rdata;
    logic [15:0] pushed_word;

    int checks = 0;
    int errors = 0;

    assign data_bus = mem_drive ? mem_rdata : 16'bz;

    bus_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ie          (ie),
        .interrupts  (interrupts),
        .irq_ack     (irq_ack),
        .address_bus (address_bus),
        .data_bus    (data_bus),
        .r           (r),
        .w           (w),
        .mem_ready   (mem_ready),
        .halt        (halt),
        .bus_error   (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one command for a single cycle (sequencer assumed ready)
    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Finish the pending access with no wait state, returning rd on reads
    task automatic complete(input logic [15:0] rd);
        mem_ready = 1'b1;
        mem_drive = r;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        mem_drive = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        ie = 1'b0; interrupts = '0; mem_ready = 1'b0; mem_drive = 1'b0; mem_rdata = '0;
        pushed_word = 16'hBEEF;
        repeat (3) tick();

        // Reset state
        chk("rst_addr", address_bus, 16'h0000);
        chk("rst_r", r, 1'b0);
        chk("rst_w", w, 1'b0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 16'h0000);
        chk("rst_irq_ack", irq_ack, 8'h00);
        chk("rst_bus_error", bus_error, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        tick();

        // FETCH with no wait: r for one cycle, response two cycles after accept
        issue(CMD_FETCH, 16'h0000, 16'h0000);
        chk("fetch_addr", address_bus, 16'h0000);
        chk("fetch_r", r, 1'b1);
        chk("fetch_w", w, 1'b0);
        chk("fetch_no_early_rsp", rsp_valid, 1'b0);
        complete(16'h1234);
        chk("fetch_r_drop", r, 1'b0);
        chk("fetch_rsp_valid", rsp_valid, 1'b1);
        chk("fetch_rsp_data", rsp_data, 16'h1234);
        tick();
        chk("fetch_rsp_pulse", rsp_valid, 1'b0);
        chk("fetch_rsp_data_clear", rsp_data, 16'h0000);

        // PUSH BEEF with two wait states
        issue(CMD_PUSH, 16'h0000, pushed_word);
        chk("push_addr", address_bus, 16'h07FF);
        chk("push_w", w, 1'b1);
        chk("push_bus", data_bus, 16'hBEEF);
        tick();
        chk("push_w_wait1", w, 1'b1);
        chk("push_addr_wait1", address_bus, 16'h07FF);
        chk("push_no_rsp_wait1", rsp_valid, 1'b0);
        tick();
        chk("push_w_wait2", w, 1'b1);
        chk("push_bus_wait2", data_bus, 16'hBEEF);
        complete(16'h0000);
        chk("push_w_drop", w, 1'b0);
        chk("push_rsp_valid", rsp_valid, 1'b1);
        chk("push_rsp_data", rsp_data, 16'h0000);
        tick();

        // POP returns the pushed word from SP+1
        issue(CMD_POP, 16'h0000, 16'h0000);
        chk("pop_addr", address_bus, 16'h07FF);
        chk("pop_r", r, 1'b1);
        complete(pushed_word);
        chk("pop_rsp_valid", rsp_valid, 1'b1);
        chk("pop_rsp_data", rsp_data, 16'hBEEF);
        tick();

        // Second FETCH shows PC advanced to 0001
        issue(CMD_FETCH, 16'h0000, 16'h0000);
        chk("fetch2_addr", address_bus, 16'h0001);
        complete(16'h5A5A);
        chk("fetch2_rsp_data", rsp_data, 16'h5A5A);
        tick();

        // LOAD and STORE
        issue(CMD_LOAD, 16'h1234, 16'h0000);
        chk("load_addr", address_bus, 16'h1234);
        chk("load_r", r, 1'b1);
        complete(16'hCAFE);
        chk("load_rsp_data", rsp_data, 16'hCAFE);
        tick();
        issue(CMD_STORE, 16'h2000, 16'h1111);
        chk("store_addr", address_bus, 16'h2000);
        chk("store_w", w, 1'b1);
        chk("store_r", r, 1'b0);
        chk("store_bus", data_bus, 16'h1111);
        complete(16'h0000);
        chk("store_rsp_valid", rsp_valid, 1'b1);
        chk("store_rsp_data", rsp_data, 16'h0000);
        tick();

        // JUMP responds the next cycle without a bus access
        issue(CMD_JUMP, 16'h0040, 16'h0000);
        chk("jump_rsp_valid", rsp_valid, 1'b1);
        chk("jump_r", r, 1'b0);
        chk("jump_w", w, 1'b0);

        // Interrupt beats a command offered in the same cycle; line 2 wins over 5
        interrupts = 8'b0010_0100;
        ie         = 1'b1;
        cmd_valid  = 1'b1;
        cmd_op     = CMD_LOAD;
        cmd_addr   = 16'h3000;
        #1;
        chk("irq_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        chk("irq_push_w", w, 1'b1);
        chk("irq_push_addr", address_bus, 16'h07FF);
        chk("irq_push_bus", data_bus, 16'h0040);
        chk("irq_push_r", r, 1'b0);
        chk("irq_ack_early", irq_ack, 8'h00);
        interrupts = 8'h00;
        #1;
        chk("irq_busy_cmd_ready", cmd_ready, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("irq_w_drop", w, 1'b0);
        chk("irq_ack", irq_ack, 8'b0000_0100);
        chk("irq_no_rsp", rsp_valid, 1'b0);
        chk("irq_cmd_ready_back", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("post_irq_load_addr", address_bus, 16'h3000);
        chk("post_irq_load_r", r, 1'b1);
        chk("irq_ack_pulse", irq_ack, 8'h00);
        complete(16'h7777);
        chk("post_irq_load_data", rsp_data, 16'h7777);
        tick();
        issue(CMD_FETCH, 16'h0000, 16'h0000);
        chk("vector_pc", address_bus, 16'hFF02);
        complete(16'h0000);
        tick();

        // Drain SP from 07FE down to 0000, then check wrap in both directions
        for (int i = 0; i < 'h7FE; i++) begin
            issue(CMD_PUSH, 16'h0000, 16'(i));
            complete(16'h0000);
        end
        issue(CMD_PUSH, 16'h0000, 16'hAAAA);
        chk("push_sp_zero_addr", address_bus, 16'h0000);
        complete(16'h0000);
        issue(CMD_PUSH, 16'h0000, 16'h5555);
        chk("sp_wrap_down", address_bus, 16'hFFFF);
        complete(16'h0000);
        issue(CMD_POP, 16'h0000, 16'h0000);
        chk("pop_near_max_addr", address_bus, 16'hFFFF);
        complete(16'h5555);
        issue(CMD_POP, 16'h0000, 16'h0000);
        chk("sp_wrap_up", address_bus, 16'h0000);
        complete(16'hAAAA);
        chk("pop_wrap_data", rsp_data, 16'hAAAA);
        tick();

        // HALT, masked interrupt keeps it halted, enabled interrupt resumes
        ie = 1'b0;
        issue(CMD_HALT, 16'h0000, 16'h0000);
        chk("halt_high", halt, 1'b1);
        chk("halt_rsp_valid", rsp_valid, 1'b1);
        chk("halt_cmd_ready", cmd_ready, 1'b0);
        interrupts = 8'h01;
        cmd_valid  = 1'b1;
        cmd_op     = CMD_FETCH;
        repeat (3) tick();
        chk("halt_masked_halt", halt, 1'b1);
        chk("halt_masked_r", r, 1'b0);
        chk("halt_masked_w", w, 1'b0);
        chk("halt_masked_ready", cmd_ready, 1'b0);
        ie = 1'b1;
        tick();
        chk("halt_irq_w", w, 1'b1);
        chk("halt_irq_addr", address_bus, 16'h0000);
        chk("halt_irq_bus", data_bus, 16'hFF03);
        chk("halt_irq_still_halted", halt, 1'b1);
        interrupts = 8'h00;
        mem_ready  = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("halt_irq_cleared", halt, 1'b0);
        chk("halt_irq_ack", irq_ack, 8'h01);
        tick();
        cmd_valid = 1'b0;
        chk("vector0_fetch_addr", address_bus, 16'hFF00);
        chk("vector0_fetch_r", r, 1'b1);
        complete(16'h0000);
        tick();

        // Reset during an access drops it without a response
        ie = 1'b0;
        issue(CMD_LOAD, 16'h4444, 16'h0000);
        chk("midrst_r_before", r, 1'b1);
        reset = 1'b1;
        tick();
        chk("midrst_r", r, 1'b0);
        chk("midrst_rsp", rsp_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk("midrst_rsp_after", rsp_valid, 1'b0);
        issue(CMD_FETCH, 16'h0000, 16'h0000);
        chk("midrst_pc_reset", address_bus, 16'h0000);
        complete(16'h0000);
        tick();

`ifdef CPU_BUS_TIMEOUT_EN
        // Fifteen stalled cycles abort the access
        issue(CMD_FETCH, 16'h0000, 16'h0000);
        mem_ready = 1'b0;
        repeat (14) tick();
        chk("tmo_r_held", r, 1'b1);
        chk("tmo_no_error_yet", bus_error, 1'b0);
        tick();
        chk("tmo_bus_error", bus_error, 1'b1);
        chk("tmo_halt", halt, 1'b1);
        chk("tmo_r_drop", r, 1'b0);
        tick();
        chk("tmo_error_pulse", bus_error, 1'b0);
        chk("tmo_no_rsp", rsp_valid, 1'b0);
        chk("tmo_halted", halt, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
